// File: rtl/watch_pkg.sv
// Shared stopwatch definitions: seven-segment patterns, time field limits,
// the display digit type and binary-to-decimal digit helpers.
package watch_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [5:0] SEC_LIMIT  = 6'd59;
   localparam logic [5:0] MIN_LIMIT  = 6'd59;
   localparam logic [4:0] HOUR_LIMIT = 5'd23;

   // Segment order {a,b,c,d,e,f,g,dp}; dp is left clear here
   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hF6;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   function automatic digit_t tens_of(input logic [5:0] value);
      return digit_t'(value / 6'd10);
   endfunction

   function automatic digit_t ones_of(input logic [5:0] value);
      return digit_t'(value % 6'd10);
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Decimal digit plus decimal point to active-high seven-segment pattern.
module seg7_encode
   import watch_pkg::*;
(
   input  digit_t     digit,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] pattern_s;

   // Pattern lookup; out-of-range codes blank the digit
   always_comb begin
      case (digit)
         4'd0:    pattern_s = SEG_0;
         4'd1:    pattern_s = SEG_1;
         4'd2:    pattern_s = SEG_2;
         4'd3:    pattern_s = SEG_3;
         4'd4:    pattern_s = SEG_4;
         4'd5:    pattern_s = SEG_5;
         4'd6:    pattern_s = SEG_6;
         4'd7:    pattern_s = SEG_7;
         4'd8:    pattern_s = SEG_8;
         4'd9:    pattern_s = SEG_9;
         default: pattern_s = SEG_BLANK;
      endcase
      seg = pattern_s | {7'd0, dp};
   end

endmodule

// File: rtl/stopwatch_hms.sv
// MM:SS / HH:MM:SS stopwatch with multiplexed seven-segment scan output.
// Define LAP_EN to add the lap port and display-hold latch.
module stopwatch_hms
   import watch_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int SCAN_DIV   = 1,
   parameter int NUM_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_stop,
   input  logic                  clear,
`ifdef LAP_EN
   input  logic                  lap,
`endif
   output logic [NUM_DIGITS-1:0] seg_com,
   output logic [7:0]            seg_data,
   output logic                  wrap,
   output logic                  running
);

   localparam int              PW         = $clog2(TICK_DIV);
   localparam int              SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam bit              HAS_HOURS  = (NUM_DIGITS == 6);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);
   localparam logic [1:0]      LAST_FIELD = 2'(NUM_DIGITS / 2 - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [5:0]            sec_q, sec_d, min_q, min_d;
   logic [4:0]            hr_q, hr_d;
   logic                  running_q, running_d, wrap_q, wrap_d;
   logic [SW-1:0]         scan_div_q, scan_div_d;
   logic [2:0]            scan_idx_q, scan_idx_d;
   logic [NUM_DIGITS-1:0] seg_com_q, seg_com_d;
   logic [7:0]            seg_data_q, seg_s;
   logic                  tick_s, full_s, dp_s;
   logic [5:0]            show_sec_s, show_min_s, field_s;
   logic [4:0]            show_hr_s;
   digit_t                digit_s;

   // Time base: prescaler, cascaded time fields, run state and rollover pulse
   always_comb begin
      presc_d   = presc_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hr_d      = hr_q;
      wrap_d    = 1'b0;
      running_d = running_q ^ start_stop;
      tick_s    = running_q && (presc_q == PRESC_LAST);
      full_s    = (sec_q == SEC_LIMIT) && (min_q == MIN_LIMIT) &&
                  (!HAS_HOURS || (hr_q == HOUR_LIMIT));
      if (clear) begin
         presc_d   = '0;
         sec_d     = 6'd0;
         min_d     = 6'd0;
         hr_d      = 5'd0;
         running_d = 1'b0;
      end else if (tick_s) begin
         presc_d = '0;
         wrap_d  = full_s;
         if (sec_q != SEC_LIMIT) begin
            sec_d = sec_q + 6'd1;
         end else begin
            sec_d = 6'd0;
            if (min_q != MIN_LIMIT) begin
               min_d = min_q + 6'd1;
            end else begin
               min_d = 6'd0;
               if (HAS_HOURS && (hr_q != HOUR_LIMIT)) begin
                  hr_d = hr_q + 5'd1;
               end else begin
                  hr_d = 5'd0;
               end
            end
         end
      end else if (running_q) begin
         presc_d = presc_q + PW'(1);
      end else begin
         presc_d = presc_q;
      end
   end

   // Digit scan runs continuously, independent of the run state
   always_comb begin
      if (scan_div_q == SCAN_LAST) begin
         scan_div_d = '0;
         scan_idx_d = (scan_idx_q == IDX_LAST) ? 3'd0 : scan_idx_q + 3'd1;
      end else begin
         scan_div_d = scan_div_q + SW'(1);
         scan_idx_d = scan_idx_q;
      end
   end

`ifdef LAP_EN
   logic       hold_q, hold_d;
   logic [5:0] snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
   logic [4:0] snap_hr_q, snap_hr_d;

   // Lap toggles the hold; entering hold snapshots the live time
   always_comb begin
      hold_d     = hold_q;
      snap_sec_d = snap_sec_q;
      snap_min_d = snap_min_q;
      snap_hr_d  = snap_hr_q;
      if (clear) begin
         hold_d = 1'b0;
      end else if (lap) begin
         hold_d = ~hold_q;
         if (!hold_q) begin
            snap_sec_d = sec_q;
            snap_min_d = min_q;
            snap_hr_d  = hr_q;
         end else begin
            snap_sec_d = snap_sec_q;
         end
      end else begin
         hold_d = hold_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_q     <= 1'b0;
         snap_sec_q <= 6'd0;
         snap_min_q <= 6'd0;
         snap_hr_q  <= 5'd0;
      end else begin
         hold_q     <= hold_d;
         snap_sec_q <= snap_sec_d;
         snap_min_q <= snap_min_d;
         snap_hr_q  <= snap_hr_d;
      end
   end

   assign show_sec_s = hold_q ? snap_sec_q : sec_q;
   assign show_min_s = hold_q ? snap_min_q : min_q;
   assign show_hr_s  = hold_q ? snap_hr_q  : hr_q;
`else
   assign show_sec_s = sec_q;
   assign show_min_s = min_q;
   assign show_hr_s  = hr_q;
`endif

   // Field k occupies digits 2k (tens) and 2k+1 (ones), most significant first
   always_comb begin
      field_s = 6'd0;
      case (scan_idx_q[2:1])
         2'd0:    field_s = HAS_HOURS ? {1'b0, show_hr_s} : show_min_s;
         2'd1:    field_s = HAS_HOURS ? show_min_s : show_sec_s;
         2'd2:    field_s = show_sec_s;
         default: field_s = 6'd0;
      endcase
      digit_s = scan_idx_q[0] ? ones_of(field_s) : tens_of(field_s);
      dp_s    = scan_idx_q[0] && (scan_idx_q[2:1] != LAST_FIELD);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg_com_d[i] = (scan_idx_q != 3'(NUM_DIGITS - 1 - i));
      end
   end

   seg7_encode u_seg7_encode (
      .digit (digit_s),
      .dp    (dp_s),
      .seg   (seg_s)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q    <= '0;
         sec_q      <= 6'd0;
         min_q      <= 6'd0;
         hr_q       <= 5'd0;
         running_q  <= 1'b0;
         wrap_q     <= 1'b0;
         scan_div_q <= '0;
         scan_idx_q <= 3'd0;
         seg_com_q  <= '1;
         seg_data_q <= 8'h00;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hr_q       <= hr_d;
         running_q  <= running_d;
         wrap_q     <= wrap_d;
         scan_div_q <= scan_div_d;
         scan_idx_q <= scan_idx_d;
         seg_com_q  <= seg_com_d;
         seg_data_q <= seg_s;
      end
   end

   assign seg_com  = seg_com_q;
   assign seg_data = seg_data_q;
   assign wrap     = wrap_q;
   assign running  = running_q;

endmodule

// File: doc/stopwatch_hms.md
STOPWATCH_HMS -- requirements
Module: stopwatch_hms

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per one-second tick, legal range 2 or more.
REQ-002 SHALL have parameter SCAN_DIV, default 1: clk cycles per digit scan step, legal range 1 or more.
REQ-003 SHALL have parameter NUM_DIGITS, default 4: 4 shows MM:SS and 6 shows HH:MM:SS; any other value is illegal.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start_stop, input, 1 bit: 1-cycle pulse that toggles the run state.
REQ-007 SHALL have port clear, input, 1 bit: 1-cycle pulse that zeroes the time and stops the watch.
REQ-008 SHALL have port lap, input, 1 bit: 1-cycle pulse that toggles display hold; present only under LAP_EN.
REQ-009 SHALL have port seg_com, output, NUM_DIGITS bits: active-low one-hot digit enable; the MSB is the leftmost digit.
REQ-010 SHALL have port seg_data, output, 8 bits: active-high segments {a,b,c,d,e,f,g,dp}, with bit7 = a and bit0 = dp.
REQ-011 SHALL have port wrap, output, 1 bit: 1-cycle pulse on full-scale rollover.
REQ-012 SHALL have port running, output, 1 bit: current run state.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 only while running and SHALL hold its value while stopped, so a partial second is retained.
REQ-014 Tick SHALL occur when the prescaler equals TICK_DIV-1 while running; the seconds field SHALL update on that same edge, and the prescaler SHALL return to 0.
REQ-015 Seconds SHALL count 0..59. On a tick at 59, seconds SHALL go to 0 and minutes SHALL increment on the same edge.
REQ-016 Minutes SHALL count 0..59. For NUM_DIGITS=6, hours SHALL count 0..23 with a carry from minutes.
REQ-017 Full-scale rollover (59:59 -> 00:00, or 23:59:59 -> 00:00:00) SHALL assert wrap for exactly the cycle after the rollover edge; counting SHALL continue.
REQ-018 start_stop SHALL toggle running on the next edge.
REQ-019 clear SHALL zero all fields and the prescaler and SHALL force running=0; when clear and start_stop coincide, clear SHALL win.
REQ-020 Scan index SHALL advance every SCAN_DIV cycles from 0 (leftmost) to NUM_DIGITS-1 and then wrap to 0, independent of the run state.
REQ-021 Each field SHALL be split into a tens digit and a ones digit; digit index 2k SHALL be the tens of field k and index 2k+1 the ones, with fields ordered most-significant first.
REQ-022 The dp bit SHALL be 1 on the ones digit of every field except the last, as the separator.
REQ-023 seg_com and seg_data SHALL be registered and SHALL reflect the scan index with exactly 1 cycle of latency; exactly one seg_com bit SHALL be low outside reset.
REQ-024 Digit patterns 0..9 SHALL be standard seven-segment codes (for example 0 = 0xFC and 1 = 0x60 before dp is ORed in).

Reset
REQ-025 While rst=0, time, prescaler, scan index and scan divider SHALL be 0, and running=0, wrap=0, seg_com all ones, seg_data=0x00 and hold=0.
REQ-026 Reset SHALL override all other inputs on the same edge, including mid-count and mid-hold.

Configuration
REQ-027 With LAP_EN defined, the lap port and a display-hold latch SHALL exist. A lap pulse SHALL freeze the displayed digits while counting continues; a second lap pulse SHALL release the display to live time; clear SHALL also release it.
REQ-028 Without LAP_EN, the lap port and the hold logic SHALL be absent, and the display SHALL always show live time.

Structure
REQ-029 The shared package watch_pkg SHALL hold the seven-segment pattern constants, the field limits (59, 23) and the digit type typedef.
REQ-030 A single sub-module seg7_encode (4-bit digit plus dp -> 8-bit pattern) SHALL be instantiated once in the scan output path.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-031 Drive rst=0, then start_stop; after 4 clk cycles -> seconds=1; after 240 cycles -> 01:00.
REQ-032 Preload to 59:59 (NUM_DIGITS=4) and run for 4 cycles -> 00:00, with wrap high exactly 1 cycle. For NUM_DIGITS=6, 23:59:59 -> 00:00:00.
REQ-033 Stop after 2 prescaler counts and wait 100 cycles, then start -> next tick after exactly 2 further cycles.
REQ-034 Assert clear and start_stop on the same edge while running -> time 00:00 and running=0.
REQ-035 With time 12:34 -> seg_com sequence 0111, 1011, 1101, 1110, each lasting 2 cycles, and seg_data 0x60, 0xDB|1, 0xF2, 0x66.
REQ-036 With LAP_EN: lap at 00:03, run 8 cycles -> display shows 00:03 and the internal time is 00:05; a second lap -> display shows 00:05.
